// File: rtl/jtkiwi_shram_if.sv
// Shared-RAM bus bundle: main CPU request/response plus sub CPU RAM port.
interface jtkiwi_shram_if #(
   parameter int unsigned AW = 13
);
   logic          main_cs;
   logic          main_rnw;
   logic [AW-1:0] main_addr;
   logic [7:0]    main_din;
   logic [7:0]    main_dout;
   logic          main_busy;
   logic          ram_cs;
   logic          cpu_rnw;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_din;
   logic [7:0]    ram_dout;
   logic          mshramen;

   modport master (
      output main_cs, main_rnw, main_addr, main_din,
      output ram_cs, cpu_rnw, ram_addr, ram_din,
      input  main_dout, main_busy, ram_dout, mshramen
   );

   modport slave (
      input  main_cs, main_rnw, main_addr, main_din,
      input  ram_cs, cpu_rnw, ram_addr, ram_din,
      output main_dout, main_busy, ram_dout, mshramen
   );
endinterface

// File: rtl/jtkiwi_shram.sv
// Kiwi shared work RAM: arbitrates main and sub CPU accesses onto one
// single-port synchronous RAM, three cycles per access.
module jtkiwi_shram #(
   parameter int unsigned AW        = 13,
   parameter bit          MAIN_PRIO = 1'b0
)(
   input  logic           clk,
   input  logic           comb_rstn,
   jtkiwi_shram_if.slave  bus
);
   localparam int unsigned DEPTH = 2 ** AW;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_CAP  = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_sel_sub;
   logic          r_last_sub;
   logic          r_rnw;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [7:0]    r_din;
   logic [7:0]    r_q;
   logic [7:0]    r_main_dout;
   logic [7:0]    r_sub_dout;
   logic          r_main_done;
   logic          r_sub_done;
   logic          r_main_rnw_l;
   logic          r_sub_rnw_l;
   logic [7:0]    r_mem [DEPTH];

   logic          w_main_req;
   logic          w_sub_req;
   logic          w_gnt_sub;
   logic          w_gnt_rnw;
   logic          w_cap_main;
   logic          w_cap_sub;
   logic          w_main_wfall;
   logic          w_sub_wfall;

   assign w_main_req   = bus.main_cs & ~r_main_done;
   assign w_sub_req    = bus.ram_cs  & ~r_sub_done;
   // Sub wins only when alone, or on a tie when main went last and main has no priority
   assign w_gnt_sub    = w_sub_req & ~(w_main_req & (MAIN_PRIO | r_last_sub));
   assign w_gnt_rnw    = w_gnt_sub ? bus.cpu_rnw : bus.main_rnw;
   assign w_cap_main   = (r_state == ST_CAP) & ~r_sel_sub;
   assign w_cap_sub    = (r_state == ST_CAP) &  r_sel_sub;
   assign w_main_wfall = r_main_rnw_l & ~bus.main_rnw;
   assign w_sub_wfall  = r_sub_rnw_l  & ~bus.cpu_rnw;

   assign bus.main_busy = w_main_req;
   assign bus.mshramen  = w_sub_req;
   assign bus.main_dout = r_main_dout;
   assign bus.ram_dout  = r_sub_dout;

   // Access sequencer: grant/latch, drive RAM, capture read data
   always_ff @(posedge clk or negedge comb_rstn) begin
      if (!comb_rstn) begin
         r_state     <= ST_IDLE;
         r_sel_sub   <= 1'b0;
         r_last_sub  <= 1'b1;
         r_rnw       <= 1'b1;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_din       <= 8'h00;
         r_main_dout <= 8'h00;
         r_sub_dout  <= 8'h00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_main_req || w_sub_req) begin
                  r_sel_sub  <= w_gnt_sub;
                  r_last_sub <= w_gnt_sub;
                  r_rnw      <= w_gnt_rnw;
                  r_we       <= ~w_gnt_rnw;
                  r_addr     <= w_gnt_sub ? bus.ram_addr : bus.main_addr;
                  r_din      <= w_gnt_sub ? bus.ram_din  : bus.main_din;
                  r_state    <= ST_ACC;
               end
            end
            ST_ACC: begin
               r_we    <= 1'b0;
               r_state <= ST_CAP;
            end
            ST_CAP: begin
               if (r_rnw) begin
                  if (r_sel_sub) r_sub_dout  <= r_q;
                  else           r_main_dout <= r_q;
               end
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // A port is done once served; a fresh select or a read-to-write turn rearms it
   always_ff @(posedge clk or negedge comb_rstn) begin
      if (!comb_rstn) begin
         r_main_done  <= 1'b0;
         r_sub_done   <= 1'b0;
         r_main_rnw_l <= 1'b1;
         r_sub_rnw_l  <= 1'b1;
      end else begin
         r_main_rnw_l <= bus.main_rnw;
         r_sub_rnw_l  <= bus.cpu_rnw;
         if (!bus.main_cs || w_main_wfall) r_main_done <= 1'b0;
         else if (w_cap_main)              r_main_done <= 1'b1;
         if (!bus.ram_cs || w_sub_wfall)   r_sub_done  <= 1'b0;
         else if (w_cap_sub)               r_sub_done  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (r_we) r_mem[r_addr] <= r_din;
      r_q <= r_mem[r_addr];
   end
endmodule
